// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register for PC + payload with valid/ready,
// flush, optional 2-entry skid buffer and a saturating back-pressure counter.
module pipe_stage_reg #(
    parameter int              PC_W     = 32,
    parameter int              DATA_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter bit              SKID     = 1'b1,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    state_t            state, state_nx;
    logic              rdy_q;
    logic              in_fire, out_fire;
    logic              load_m, load_s, take_s;
    logic [PC_W-1:0]   m_pc, s_pc;
    logic [DATA_W-1:0] m_data, s_data;

    assign out_valid = state != ST_EMPTY;
    // With the skid buffer in_ready comes straight from a flop, cutting the ready path.
    assign in_ready  = SKID ? rdy_q : (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_pc    = m_pc;
    assign out_data  = m_data;

    always_comb begin
        state_nx = state;
        load_m   = 1'b0;
        load_s   = 1'b0;
        take_s   = 1'b0;
        if (flush) begin
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    state_nx = in_fire ? ST_FULL : ST_EMPTY;
                    load_m   = in_fire;
                end
                ST_FULL: begin
                    load_m   = in_fire && out_fire;
                    load_s   = in_fire && !out_fire;
                    state_nx = load_s ? ST_SKID : (!in_fire && out_fire) ? ST_EMPTY : ST_FULL;
                end
                ST_SKID: begin
                    take_s   = out_fire;
                    state_nx = out_fire ? ST_FULL : ST_SKID;
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
            rdy_q <= 1'b1;
        end else begin
            state <= state_nx;
            rdy_q <= state_nx != ST_SKID;
        end
    end

    // Payload only moves on accepted entries, so idle inputs never reach out_*.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc   <= RESET_PC;
            m_data <= '0;
            s_pc   <= '0;
            s_data <= '0;
        end else begin
            if (load_m) begin
                m_pc   <= in_pc;
                m_data <= in_data;
            end else if (take_s) begin
                m_pc   <= s_pc;
                m_data <= s_data;
            end
            if (load_s) begin
                s_pc   <= in_pc;
                s_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg (SKID=1 and SKID=0)
// against a queue-based reference model.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_data = '0;

    logic        r1_ready, r1_valid;
    logic [31:0] r1_pc, r1_data;
    logic [15:0] r1_cnt;
    logic        r0_ready, r0_valid;
    logic [31:0] r0_pc, r0_data;
    logic [3:0]  r0_cnt;

    logic        sel = 1'b1;
    logic        obs_ready, obs_valid;
    logic [31:0] obs_pc, obs_data;
    logic [15:0] obs_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    ent_t shown;
    int   stall;

    always #5 clk = ~clk;

    pipe_stage_reg #(.PC_W(32), .DATA_W(32), .RESET_PC(32'h100), .SKID(1'b1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r1_ready),
        .in_pc(in_pc), .in_data(in_data), .out_valid(r1_valid), .out_ready(out_ready),
        .out_pc(r1_pc), .out_data(r1_data), .stall_cnt(r1_cnt));

    pipe_stage_reg #(.PC_W(32), .DATA_W(32), .RESET_PC(32'h200), .SKID(1'b0), .CNT_W(4)) u0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r0_ready),
        .in_pc(in_pc), .in_data(in_data), .out_valid(r0_valid), .out_ready(out_ready),
        .out_pc(r0_pc), .out_data(r0_data), .stall_cnt(r0_cnt));

    assign obs_ready = sel ? r1_ready : r0_ready;
    assign obs_valid = sel ? r1_valid : r0_valid;
    assign obs_pc    = sel ? r1_pc : r0_pc;
    assign obs_data  = sel ? r1_data : r0_data;
    assign obs_cnt   = sel ? r1_cnt : {12'b0, r0_cnt};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return sel ? (q.size() < 2) : (q.size() == 0 || out_ready);
    endfunction

    function automatic int cnt_max();
        return sel ? 65535 : 15;
    endfunction

    task automatic model_reset();
        q.delete();
        shown = '{pc: (sel ? 32'h100 : 32'h200), data: 32'h0};
        stall = 0;
    endtask

    task automatic model_step();
        logic inf, outf;
        inf  = in_valid && m_ready();
        outf = q.size() > 0 && out_ready;
        if (q.size() > 0 && !out_ready && stall < cnt_max()) stall++;
        if (flush) q.delete();
        else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back('{pc: in_pc, data: in_data});
        end
        if (q.size() > 0) shown = q[0];
    endtask

    task automatic compare_all();
        check("out_valid", obs_valid, q.size() > 0);
        check("in_ready", obs_ready, m_ready());
        check("out_pc", obs_pc, shown.pc);
        check("out_data", obs_data, shown.data);
        check("stall_cnt", obs_cnt, stall);
    endtask

    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input logic v, input logic r, input logic [31:0] pc, input logic f);
        in_valid = v;
        out_ready = r;
        in_pc = pc;
        in_data = $urandom;
        flush = f;
    endtask

    task automatic drive_rand(input int pflush);
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom,
              $urandom_range(0, 99) < pflush);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        sel = 1'b1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'h3000 + 32'(4 * i), 1'b0);
            tick();
        end
        check("stream_pc", obs_pc, 32'h301c);
        check("stream_stall", obs_cnt, 0);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        tick();

        do_reset();
        drive(1'b1, 1'b0, 32'h3000, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h3004, 1'b0);
        tick();
        check("bp_in_ready", obs_ready, 0);
        drive(1'b1, 1'b0, 32'h3008, 1'b0);
        tick();
        tick();
        check("bp_stall", obs_cnt, 3);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        check("bp_head0", obs_pc, 32'h3000);
        tick();
        check("bp_head1", obs_pc, 32'h3004);
        tick();

        drive(1'b1, 1'b0, 32'h3000, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h3004, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h3008, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check("fl_valid", obs_valid, 0);
        check("fl_ready", obs_ready, 1);
        check("fl_pc", obs_pc, 32'h3000);
        tick();
        tick();

        drive(1'b1, 1'b0, 32'h3010, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("ar_pre_valid", obs_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", obs_valid, 0);
        check("ar_pc", obs_pc, 32'h100);
        check("ar_cnt", obs_cnt, 0);
        check("ar_ready", obs_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            drive_rand(3);
            tick();
        end

        sel = 1'b0;
        do_reset();
        drive(1'b1, 1'b1, 32'h4000, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt", obs_cnt, 15);
        check("sat_pc", obs_pc, 32'h4000);

        for (int i = 0; i < 10000; i++) begin
            drive_rand(1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
